// File: rtl/rvga_mem_arbiter_pkg.sv
// Shared types for the imem/dmem memory-port arbiter.
// Holds FSM state, owner encoding and the latched request bundle.
package rvga_mem_arbiter_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] rvga_word;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } rvga_arb_state_e;

  typedef enum logic {
    OWN_IMEM,
    OWN_DMEM
  } rvga_mem_owner_e;

  typedef struct packed {
    rvga_mem_owner_e owner;
    logic            we;
    rvga_word        addr;
    rvga_word        wdata;
    rvga_word        snap;
  } arb_req_t;

endpackage

// File: rtl/rvga_mem_arbiter_if.sv
// Core-side (imem/dmem) and memory-side signals of the arbiter.
// slave: arbiter view; master: core + memory view.
interface rvga_mem_arbiter_if;
  import rvga_mem_arbiter_pkg::*;

  logic     imem_r_v_i;
  rvga_word imem_addr_i;
  rvga_word imem_data_o;
  logic     imem_resp_v_o;

  logic     dmem_r_v_i;
  logic     dmem_w_v_i;
  rvga_word dmem_addr_i;
  rvga_word dmem_data_i;
  rvga_word dmem_data_o;
  logic     dmem_resp_v_o;

  logic     mem_r_v_o;
  logic     mem_w_v_o;
  rvga_word mem_addr_o;
  rvga_word mem_data_o;
  logic     mem_ready_i;
  rvga_word mem_data_i;
  logic     mem_resp_v_i;

  modport slave (
    input  imem_r_v_i,
    input  imem_addr_i,
    output imem_data_o,
    output imem_resp_v_o,
    input  dmem_r_v_i,
    input  dmem_w_v_i,
    input  dmem_addr_i,
    input  dmem_data_i,
    output dmem_data_o,
    output dmem_resp_v_o,
    output mem_r_v_o,
    output mem_w_v_o,
    output mem_addr_o,
    output mem_data_o,
    input  mem_ready_i,
    input  mem_data_i,
    input  mem_resp_v_i
  );

  modport master (
    output imem_r_v_i,
    output imem_addr_i,
    input  imem_data_o,
    input  imem_resp_v_o,
    output dmem_r_v_i,
    output dmem_w_v_i,
    output dmem_addr_i,
    output dmem_data_i,
    input  dmem_data_o,
    input  dmem_resp_v_o,
    input  mem_r_v_o,
    input  mem_w_v_o,
    input  mem_addr_o,
    input  mem_data_o,
    output mem_ready_i,
    output mem_data_i,
    output mem_resp_v_i
  );

endinterface

// File: rtl/rvga_arb_pick.sv
// Owner selection: fixed dmem priority with an imem starvation counter.
// Ports: clk_i, rst_i, arb_i (arbitration this cycle), imem_req, dmem_req -> owner.
module rvga_arb_pick
  import rvga_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            arb_i,
  input  logic            imem_req,
  input  logic            dmem_req,
  output rvga_mem_owner_e owner
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_imem;

  // imem has lost LIMIT contested rounds in a row: it takes this one
  assign force_imem = imem_req && (starve_cnt == LIMIT);
  assign owner = (dmem_req && !force_imem) ? OWN_DMEM : OWN_IMEM;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (arb_i) begin
      if (owner == OWN_IMEM) begin
        starve_cnt <= '0;
      end else if (imem_req && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvga_mem_arbiter.sv
// Shares one memory port between imem fetch and dmem load/store.
// Ports: clk_i, rst_i (sync, high), bus (rvga_mem_arbiter_if.slave).
module rvga_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic               clk_i,
  input logic               rst_i,
  rvga_mem_arbiter_if.slave bus
);
  import rvga_mem_arbiter_pkg::*;

  rvga_arb_state_e state_q;
  rvga_arb_state_e state_d;
  arb_req_t        req_q;
  arb_req_t        req_d;
  rvga_mem_owner_e pick;

  logic     imem_req;
  logic     dmem_req;
  logic     arb_en;
  logic     imem_hit;
  logic     pick_we;

  logic     mem_r_v;
  logic     mem_w_v;
  rvga_word mem_addr;
  rvga_word mem_data;
  logic     imem_resp_v;
  logic     dmem_resp_v;
  rvga_word imem_data;
  rvga_word dmem_data;

  assign imem_req = bus.imem_r_v_i;
  assign dmem_req = bus.dmem_r_v_i | bus.dmem_w_v_i;
  assign arb_en   = (state_q == ARB_IDLE) && (imem_req || dmem_req);

  // fetch still wanted at the same address; otherwise the core redirected
  assign imem_hit = bus.imem_r_v_i &&
                    (bus.imem_addr_i == req_q.snap);

  assign pick_we = (pick == OWN_DMEM) && bus.dmem_w_v_i;

  rvga_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_pick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .arb_i   (arb_en),
    .imem_req(imem_req),
    .dmem_req(dmem_req),
    .owner   (pick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    mem_r_v     = 1'b0;
    mem_w_v     = 1'b0;
    mem_addr    = '0;
    mem_data    = '0;
    imem_resp_v = 1'b0;
    dmem_resp_v = 1'b0;
    imem_data   = '0;
    dmem_data   = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (arb_en) begin
          state_d     = ARB_ISSUE;
          req_d.owner = pick;
          req_d.we    = pick_we;
          req_d.snap  = bus.imem_addr_i;
          req_d.addr  = (pick == OWN_DMEM) ?
                        bus.dmem_addr_i : bus.imem_addr_i;
          req_d.wdata = pick_we ? bus.dmem_data_i : '0;
        end
      end
      ARB_ISSUE: begin
        // driven from registers only, never from core inputs
        mem_r_v  = !req_q.we;
        mem_w_v  = req_q.we;
        mem_addr = req_q.addr;
        mem_data = req_q.wdata;
        if (bus.mem_ready_i) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (bus.mem_resp_v_i) begin
          state_d = ARB_IDLE;
          if (req_q.owner == OWN_DMEM) begin
            dmem_resp_v = 1'b1;
            dmem_data   = bus.mem_data_i;
          end else if (imem_hit) begin
            imem_resp_v = 1'b1;
            imem_data   = bus.mem_data_i;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign bus.mem_r_v_o     = mem_r_v;
  assign bus.mem_w_v_o     = mem_w_v;
  assign bus.mem_addr_o    = mem_addr;
  assign bus.mem_data_o    = mem_data;
  assign bus.imem_resp_v_o = imem_resp_v;
  assign bus.imem_data_o   = imem_data;
  assign bus.dmem_resp_v_o = dmem_resp_v;
  assign bus.dmem_data_o   = dmem_data;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Testbench for rvga_mem_arbiter: directed vectors,
// hand sequences, and a randomized run against a transaction model.
module tb_rvga_mem_arbiter;
  import rvga_mem_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  rvga_mem_arbiter_if bus ();

  rvga_mem_arbiter #(
    .STARVE_LIMIT(LIMIT),
    .CNT_W       (3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [31:0] rdata;
    logic        ew;
    logic [31:0] eaddr;
    logic        to_d;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop_all();
    bus.imem_r_v_i  = 1'b0;
    bus.imem_addr_i = '0;
    bus.dmem_r_v_i  = 1'b0;
    bus.dmem_w_v_i  = 1'b0;
    bus.dmem_addr_i = '0;
    bus.dmem_data_i = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_irv"}, 32'(bus.imem_resp_v_o), 0);
    chk({tag, "_drv"}, 32'(bus.dmem_resp_v_o), 0);
    chk({tag, "_idat"}, bus.imem_data_o, 0);
    chk({tag, "_ddat"}, bus.dmem_data_o, 0);
  endtask

  task automatic await_grant(input string tag, output int waited);
    logic mv;
    waited = 0;
    mv = 1'b0;
    while (!mv && waited < 12) begin
      @(negedge clk);
      waited++;
      mv = bus.mem_r_v_o | bus.mem_w_v_o;
    end
    chk({tag, "_grant"}, 32'(mv), 1);
  endtask

  // One full transaction: grant, rdy_wait cycles of ready low,
  // accept, response next cycle, then drop the response.
  task automatic serve(input string tag, input logic exp_w,
                       input logic [31:0] exp_addr,
                       input logic [31:0] wd,
                       input logic [31:0] rdata,
                       input int rdy_wait, input logic to_d,
                       output int waited);
    bus.mem_ready_i = 1'b0;
    await_grant(tag, waited);
    chk({tag, "_w"}, 32'(bus.mem_w_v_o), 32'(exp_w));
    chk({tag, "_r"}, 32'(bus.mem_r_v_o), 32'(!exp_w));
    chk({tag, "_addr"}, bus.mem_addr_o, exp_addr);
    if (exp_w) chk({tag, "_wdata"}, bus.mem_data_o, wd);
    for (int i = 0; i < rdy_wait; i++) begin
      @(negedge clk);
      chk({tag, "_hold_v"},
          32'(bus.mem_r_v_o | bus.mem_w_v_o), 1);
      chk({tag, "_hold_a"}, bus.mem_addr_o, exp_addr);
      chk_quiet({tag, "_hold"});
    end
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    chk({tag, "_drop"}, 32'(bus.mem_r_v_o | bus.mem_w_v_o), 0);
    bus.mem_resp_v_i = 1'b1;
    bus.mem_data_i   = rdata;
    #1;
    chk({tag, "_irv"}, 32'(bus.imem_resp_v_o), 32'(!to_d));
    chk({tag, "_drv"}, 32'(bus.dmem_resp_v_o), 32'(to_d));
    chk({tag, "_data"}, to_d ? bus.dmem_data_o : bus.imem_data_o,
        rdata);
    @(negedge clk);
    bus.mem_resp_v_i = 1'b0;
    bus.mem_data_i   = '0;
    #1;
    chk_quiet({tag, "_after"});
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // randomized-phase model state
  logic        pend_i, pend_d, dwe, done_i, done_d;
  logic        arb_i, arb_d, in_txn, in0, accepted, own_d;
  logic        mv, exp_d, exp_w, resp_now, idle_prev;
  logic [31:0] ia, da, dd, t_addr, t_exp, t_wd;
  logic        t_we;
  int          losses, cd, n_i, n_d;
  logic [31:0] mem_m [logic [31:0]];

  initial begin
    int w;
    int lost;
    logic wins_i;
    logic [31:0] ia_s, da_s;

    rst = 1'b1;
    drop_all();
    bus.mem_ready_i  = 1'b0;
    bus.mem_resp_v_i = 1'b0;
    bus.mem_data_i   = '0;

    tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0,
               32'h0000_0013, 1'b0, 32'h100, 1'b0};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0,
               32'hCAFE_F00D, 1'b0, 32'h3000, 1'b1};
    tbl[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF,
               32'h1111_1111, 1'b1, 32'h2000, 1'b1};
    tbl[3] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0,
               32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 1'b0};
    tbl[4] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h4000, 32'h0,
               32'h0BAD_F00D, 1'b0, 32'h4000, 1'b1};
    tbl[5] = '{1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 32'h0,
               32'h0010_0093, 1'b0, 32'h108, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_mem_r", 32'(bus.mem_r_v_o), 0);
    chk("rst_mem_w", 32'(bus.mem_w_v_o), 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_data", bus.mem_data_o, 0);
    chk_quiet("rst");
    rst = 1'b0;

    // single-transaction vectors at minimum latency
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.imem_r_v_i  = tbl[i].iv;
      bus.imem_addr_i = tbl[i].ia;
      bus.dmem_r_v_i  = tbl[i].dr;
      bus.dmem_w_v_i  = tbl[i].dw;
      bus.dmem_addr_i = tbl[i].da;
      bus.dmem_data_i = tbl[i].dd;
      serve($sformatf("vec%0d", i), tbl[i].ew, tbl[i].eaddr,
            tbl[i].dd, tbl[i].rdata, 0, tbl[i].to_d, w);
      chk($sformatf("vec%0d_lat", i), w, 1);
      drop_all();
    end

    // both request: dmem store first, imem right after
    @(negedge clk);
    bus.imem_r_v_i  = 1'b1;
    bus.imem_addr_i = 32'h104;
    bus.dmem_w_v_i  = 1'b1;
    bus.dmem_addr_i = 32'h2000;
    bus.dmem_data_i = 32'hDEAD_BEEF;
    serve("both_d", 1'b1, 32'h2000, 32'hDEAD_BEEF, 32'h0, 0,
          1'b1, w);
    bus.dmem_w_v_i = 1'b0;
    serve("both_i", 1'b0, 32'h104, 32'h0, 32'h0000_0013, 0,
          1'b0, w);
    chk("both_i_lat", w, 1);
    drop_all();

    // starvation: imem held while dmem loads keep coming
    @(negedge clk);
    ia_s = 32'h300;
    da_s = 32'h5000;
    lost = 0;
    bus.imem_r_v_i  = 1'b1;
    bus.imem_addr_i = ia_s;
    bus.dmem_r_v_i  = 1'b1;
    bus.dmem_addr_i = da_s;
    for (int g = 0; g < 10; g++) begin
      wins_i = (lost == LIMIT);
      if (wins_i) lost = 0;
      else lost++;
      serve($sformatf("starve%0d", g), 1'b0,
            wins_i ? ia_s : da_s, 32'h0,
            (wins_i ? ia_s : da_s) ^ 32'h5A5A_0000, 0, !wins_i, w);
      if (wins_i) begin
        ia_s = ia_s + 4;
        bus.imem_addr_i = ia_s;
      end else begin
        da_s = da_s + 4;
        bus.dmem_addr_i = da_s;
      end
    end
    drop_all();

    // memory stalls five cycles in ISSUE
    @(negedge clk);
    bus.imem_r_v_i  = 1'b1;
    bus.imem_addr_i = 32'h700;
    serve("stall", 1'b0, 32'h700, 32'h0, 32'h0000_0297, 5,
          1'b0, w);
    drop_all();

    // branch redirect while waiting: fetch dropped, new one issued
    @(negedge clk);
    bus.imem_r_v_i  = 1'b1;
    bus.imem_addr_i = 32'h200;
    await_grant("flush", w);
    chk("flush_addr", bus.mem_addr_o, 32'h200);
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    bus.imem_addr_i = 32'h400;
    @(negedge clk);
    bus.mem_resp_v_i = 1'b1;
    bus.mem_data_i   = 32'h0001_2345;
    #1;
    chk_quiet("flush_resp");
    @(negedge clk);
    bus.mem_resp_v_i = 1'b0;
    bus.mem_data_i   = '0;
    serve("refetch", 1'b0, 32'h400, 32'h0, 32'h0000_006F, 0,
          1'b0, w);
    chk("refetch_lat", w, 1);
    drop_all();

    // reset while waiting for the response
    @(negedge clk);
    bus.imem_r_v_i  = 1'b1;
    bus.imem_addr_i = 32'h500;
    await_grant("rstw", w);
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_mem_r", 32'(bus.mem_r_v_o), 0);
    chk("rstw_mem_w", 32'(bus.mem_w_v_o), 0);
    chk("rstw_addr", bus.mem_addr_o, 0);
    chk_quiet("rstw");
    rst = 1'b0;
    bus.imem_addr_i = 32'h600;
    serve("post_rst", 1'b0, 32'h600, 32'h0, 32'h0000_0033, 0,
          1'b0, w);
    chk("post_rst_lat", w, 1);
    drop_all();

    // stray response while idle is ignored
    @(negedge clk);
    bus.mem_resp_v_i = 1'b1;
    bus.mem_data_i   = 32'hFFFF_0000;
    #1;
    chk_quiet("stray");
    chk("stray_mem_v", 32'(bus.mem_r_v_o | bus.mem_w_v_o), 0);
    @(negedge clk);
    bus.mem_resp_v_i = 1'b0;
    bus.mem_data_i   = '0;
    repeat (2) @(negedge clk);

    // randomized traffic against the transaction model
    pend_i = 0; pend_d = 0; dwe = 0; done_i = 0; done_d = 0;
    in_txn = 0; accepted = 0; own_d = 0; idle_prev = 1;
    ia = 0; da = 0; dd = 0; t_addr = 0; t_exp = 0; t_wd = 0;
    t_we = 0; losses = 0; cd = 0; n_i = 0; n_d = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      arb_i = pend_i;
      arb_d = pend_d;
      resp_now = 1'b0;
      bus.mem_resp_v_i = 1'b0;
      bus.mem_data_i   = '0;
      if (done_i) begin pend_i = 0; done_i = 0; end
      if (done_d) begin pend_d = 0; done_d = 0; end
      mv = bus.mem_r_v_o | bus.mem_w_v_o;
      in0 = in_txn;
      if (!in0) begin
        chk("rnd_grant", 32'(mv), 32'(idle_prev && (arb_i || arb_d)));
        if (mv) begin
          exp_d = arb_d && !(arb_i && losses == LIMIT);
          if (!exp_d) losses = 0;
          else if (arb_i) losses++;
          exp_w  = exp_d && dwe;
          t_addr = exp_d ? da : ia;
          t_we   = exp_w;
          t_wd   = dd;
          chk("rnd_w", 32'(bus.mem_w_v_o), 32'(exp_w));
          chk("rnd_addr", bus.mem_addr_o, t_addr);
          if (exp_w) chk("rnd_wdata", bus.mem_data_o, t_wd);
          in_txn = 1; accepted = 0; own_d = exp_d;
        end
      end else if (!accepted) begin
        chk("rnd_hold_v", 32'(mv), 1);
        chk("rnd_hold_a", bus.mem_addr_o, t_addr);
      end else begin
        chk("rnd_drop", 32'(mv), 0);
        if (cd == 0) begin
          resp_now = 1'b1;
          bus.mem_resp_v_i = 1'b1;
          bus.mem_data_i   = t_exp;
        end else begin
          cd--;
        end
      end
      idle_prev = !in0 && !mv;
      bus.mem_ready_i = ($urandom_range(0, 2) != 0);
      if (in_txn && !accepted && bus.mem_ready_i) begin
        accepted = 1;
        cd = $urandom_range(0, 2);
        if (t_we) begin
          mem_m[t_addr] = t_wd;
          t_exp = 32'h0;
        end else if (mem_m.exists(t_addr)) begin
          t_exp = mem_m[t_addr];
        end else begin
          t_exp = dflt(t_addr);
        end
      end
      #1;
      if (resp_now) begin
        if (own_d) begin
          chk("rnd_drv", 32'(bus.dmem_resp_v_o), 1);
          chk("rnd_ddat", bus.dmem_data_o, t_exp);
          chk("rnd_irv_off", 32'(bus.imem_resp_v_o), 0);
          done_d = 1; n_d++;
        end else begin
          chk("rnd_irv", 32'(bus.imem_resp_v_o), 1);
          chk("rnd_idat", bus.imem_data_o, t_exp);
          chk("rnd_drv_off", 32'(bus.dmem_resp_v_o), 0);
          done_i = 1; n_i++;
        end
        in_txn = 0;
      end else begin
        chk_quiet("rnd_idle");
      end
      if (!pend_i && !done_i && $urandom_range(0, 1) == 1) begin
        pend_i = 1;
        ia = {20'h0, 10'($urandom), 2'b00};
      end
      if (!pend_d && !done_d && $urandom_range(0, 1) == 1) begin
        pend_d = 1;
        dwe = 1'($urandom);
        da = {4'h1, 18'h0, 8'($urandom), 2'b00};
        dd = $urandom;
      end
      bus.imem_r_v_i  = pend_i;
      bus.imem_addr_i = ia;
      bus.dmem_r_v_i  = pend_d && !dwe;
      bus.dmem_w_v_i  = pend_d && dwe;
      bus.dmem_addr_i = da;
      bus.dmem_data_i = dd;
    end
    chk("rnd_imem_done", 32'(n_i > 20), 1);
    chk("rnd_dmem_done", 32'(n_d > 20), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
